// File: rtl/cc_sum.sv
// cc_sum: per-burst point count, signed bounding box, row count and checksum of a CC coordinate stream.
// Summary pulses 2 cycles after the last point of a burst; no backpressure, downstream samples on out_valid.
module cc_sum (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  xi,
    input  logic [7:0]  yi,
    output logic        out_valid,
    output logic [15:0] cnt,
    output logic [7:0]  x_min,
    output logic [7:0]  x_max,
    output logic [7:0]  y_min,
    output logic [7:0]  y_max,
    output logic [7:0]  rows,
    output logic [15:0] chk
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic [15:0] acc_cnt_q,  acc_cnt_d;
    logic [7:0]  acc_xmin_q, acc_xmin_d;
    logic [7:0]  acc_xmax_q, acc_xmax_d;
    logic [7:0]  acc_ymin_q, acc_ymin_d;
    logic [7:0]  acc_ymax_q, acc_ymax_d;
    logic [7:0]  acc_rows_q, acc_rows_d;
    logic [15:0] acc_chk_q,  acc_chk_d;
    logic [7:0]  prev_y_q,   prev_y_d;

    logic        out_valid_q, out_valid_d;
    logic [15:0] cnt_q,   cnt_d;
    logic [7:0]  x_min_q, x_min_d;
    logic [7:0]  x_max_q, x_max_d;
    logic [7:0]  y_min_q, y_min_d;
    logic [7:0]  y_max_q, y_max_d;
    logic [7:0]  rows_q,  rows_d;
    logic [15:0] chk_q,   chk_d;

    logic        first_pt;
    logic        next_pt;
    logic        emit;

    // A first point can arrive in IDLE or in DONE (back-to-back burst);
    // in DONE the summary has already been copied out, so reloading is safe.
    always_comb begin
        first_pt = in_valid && (state_q != ACC);
        next_pt  = in_valid && (state_q == ACC);
        emit     = !in_valid && (state_q == ACC);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_valid ? ACC : IDLE;
            ACC:     state_d = in_valid ? ACC : DONE;
            DONE:    state_d = in_valid ? ACC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_cnt_d  = acc_cnt_q;
        acc_xmin_d = acc_xmin_q;
        acc_xmax_d = acc_xmax_q;
        acc_ymin_d = acc_ymin_q;
        acc_ymax_d = acc_ymax_q;
        acc_rows_d = acc_rows_q;
        acc_chk_d  = acc_chk_q;
        prev_y_d   = prev_y_q;
        if (first_pt) begin
            acc_cnt_d  = 16'd1;
            acc_xmin_d = xi;
            acc_xmax_d = xi;
            acc_ymin_d = yi;
            acc_ymax_d = yi;
            acc_rows_d = 8'd1;
            acc_chk_d  = {xi, yi};
            prev_y_d   = yi;
        end else if (next_pt) begin
            if (acc_cnt_q != 16'hFFFF) begin
                acc_cnt_d = acc_cnt_q + 16'd1;
            end
            if ($signed(xi) < $signed(acc_xmin_q)) begin
                acc_xmin_d = xi;
            end
            if ($signed(xi) > $signed(acc_xmax_q)) begin
                acc_xmax_d = xi;
            end
            if ($signed(yi) < $signed(acc_ymin_q)) begin
                acc_ymin_d = yi;
            end
            if ($signed(yi) > $signed(acc_ymax_q)) begin
                acc_ymax_d = yi;
            end
            if ((yi != prev_y_q) && (acc_rows_q != 8'hFF)) begin
                acc_rows_d = acc_rows_q + 8'd1;
            end
            acc_chk_d = {acc_chk_q[14:0], acc_chk_q[15]} ^ {xi, yi};
            prev_y_d  = yi;
        end
    end

    always_comb begin
        out_valid_d = emit;
        cnt_d       = cnt_q;
        x_min_d     = x_min_q;
        x_max_d     = x_max_q;
        y_min_d     = y_min_q;
        y_max_d     = y_max_q;
        rows_d      = rows_q;
        chk_d       = chk_q;
        if (emit) begin
            cnt_d   = acc_cnt_q;
            x_min_d = acc_xmin_q;
            x_max_d = acc_xmax_q;
            y_min_d = acc_ymin_q;
            y_max_d = acc_ymax_q;
            rows_d  = acc_rows_q;
            chk_d   = acc_chk_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_cnt_q   <= '0;
            acc_xmin_q  <= '0;
            acc_xmax_q  <= '0;
            acc_ymin_q  <= '0;
            acc_ymax_q  <= '0;
            acc_rows_q  <= '0;
            acc_chk_q   <= '0;
            prev_y_q    <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            x_min_q     <= '0;
            x_max_q     <= '0;
            y_min_q     <= '0;
            y_max_q     <= '0;
            rows_q      <= '0;
            chk_q       <= '0;
        end else begin
            state_q     <= state_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_xmin_q  <= acc_xmin_d;
            acc_xmax_q  <= acc_xmax_d;
            acc_ymin_q  <= acc_ymin_d;
            acc_ymax_q  <= acc_ymax_d;
            acc_rows_q  <= acc_rows_d;
            acc_chk_q   <= acc_chk_d;
            prev_y_q    <= prev_y_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            x_min_q     <= x_min_d;
            x_max_q     <= x_max_d;
            y_min_q     <= y_min_d;
            y_max_q     <= y_max_d;
            rows_q      <= rows_d;
            chk_q       <= chk_d;
        end
    end

    assign out_valid = out_valid_q;
    assign cnt       = cnt_q;
    assign x_min     = x_min_q;
    assign x_max     = x_max_q;
    assign y_min     = y_min_q;
    assign y_max     = y_max_q;
    assign rows      = rows_q;
    assign chk       = chk_q;

endmodule

// File: tb/tb_cc_sum.sv
// Scoreboard bench for cc_sum: directed bursts push expected summaries, a monitor checks each pulse.
module tb_cc_sum;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  xi;
    logic [7:0]  yi;
    logic        out_valid;
    logic [15:0] cnt;
    logic [7:0]  x_min;
    logic [7:0]  x_max;
    logic [7:0]  y_min;
    logic [7:0]  y_max;
    logic [7:0]  rows;
    logic [15:0] chk;

    typedef struct {
        int          cyc;
        logic [15:0] cnt;
        logic [7:0]  xmn;
        logic [7:0]  xmx;
        logic [7:0]  ymn;
        logic [7:0]  ymx;
        logic [7:0]  rows;
        logic [15:0] chk;
        bit          chk_en;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   last_cyc = 0;

    cc_sum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .xi        (xi),
        .yi        (yi),
        .out_valid (out_valid),
        .cnt       (cnt),
        .x_min     (x_min),
        .x_max     (x_max),
        .y_min     (y_min),
        .y_max     (y_max),
        .rows      (rows),
        .chk       (chk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic pt(input logic [7:0] x, input logic [7:0] y);
        in_valid = 1'b1;
        xi       = x;
        yi       = y;
        last_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            xi       = 8'($urandom);
            yi       = 8'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_sum(input logic [15:0] c, input logic [7:0] xmn, input logic [7:0] xmx,
                              input logic [7:0] ymn, input logic [7:0] ymx, input logic [7:0] r,
                              input logic [15:0] k, input bit k_en);
        exp_t e;
        e.cyc    = last_cyc + 2;
        e.cnt    = c;
        e.xmn    = xmn;
        e.xmx    = xmx;
        e.ymn    = ymn;
        e.ymx    = ymx;
        e.rows   = r;
        e.chk    = k;
        e.chk_en = k_en;
        exp_q.push_back(e);
    endtask

    // Monitor: every out_valid cycle must match the oldest pending summary.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                check("cnt",   32'(cnt),   32'(e.cnt));
                check("x_min", 32'(x_min), 32'(e.xmn));
                check("x_max", 32'(x_max), 32'(e.xmx));
                check("y_min", 32'(y_min), 32'(e.ymn));
                check("y_max", 32'(y_max), 32'(e.ymx));
                check("rows",  32'(rows),  32'(e.rows));
                if (e.chk_en) check("chk", 32'(chk), 32'(e.chk));
            end
        end
    end

    initial begin
        int wait_cnt;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        xi       = 8'h00;
        yi       = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_cnt",   32'(cnt),   32'd0);
        check("rst_x_min", 32'(x_min), 32'd0);
        check("rst_x_max", 32'(x_max), 32'd0);
        check("rst_y_min", 32'(y_min), 32'd0);
        check("rst_y_max", 32'(y_max), 32'd0);
        check("rst_rows",  32'(rows),  32'd0);
        check("rst_chk",   32'(chk),   32'd0);
        rst_n = 1'b1;
        idle(2);

        // Single point (3,-2)
        pt(8'd3, 8'hFE);
        expect_sum(16'd1, 8'd3, 8'd3, 8'hFE, 8'hFE, 8'd1, 16'h03FE, 1'b1);
        idle(3);

        // Trapezoid row scan
        pt(8'd1, 8'd0); pt(8'd2, 8'd0); pt(8'd3, 8'd0);
        pt(8'd0, 8'd1); pt(8'd1, 8'd1); pt(8'd2, 8'd1); pt(8'd3, 8'd1); pt(8'd4, 8'd1);
        expect_sum(16'd8, 8'd0, 8'd4, 8'd0, 8'd1, 8'd2, 16'h621F, 1'b1);
        idle(3);

        // Signed extremes
        pt(8'h80, 8'h7F); pt(8'h7F, 8'h80);
        expect_sum(16'd2, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'd2, 16'h7F7F, 1'b1);
        idle(3);

        // Back-to-back with a single idle cycle; B's first point lands on A's pulse
        pt(8'd1, 8'd1); pt(8'd2, 8'd2); pt(8'd3, 8'd3);
        expect_sum(16'd3, 8'd1, 8'd3, 8'd1, 8'd3, 8'd3, 16'h0303, 1'b1);
        idle(1);
        pt(8'hFF, 8'd5); pt(8'd4, 8'hFD);
        expect_sum(16'd2, 8'hFF, 8'd4, 8'hFD, 8'd5, 8'd2, 16'hFAF6, 1'b1);
        idle(3);

        // Mid-burst reset: first three points must be discarded
        pt(8'd9, 8'd9); pt(8'd8, 8'd9); pt(8'd7, 8'd9);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        check("midrst_cnt_cleared", 32'(cnt), 32'd0);
        pt(8'd5, 8'd6); pt(8'd7, 8'd6);
        expect_sum(16'd2, 8'd5, 8'd7, 8'd6, 8'd6, 8'd1, 16'h0D0A, 1'b1);
        idle(3);

        // Saturation: 70000 points, y toggles every 256 points
        for (int i = 0; i < 70000; i++) begin
            pt(8'd0, ((i >> 8) & 1) != 0 ? 8'd1 : 8'd0);
        end
        expect_sum(16'hFFFF, 8'd0, 8'd0, 8'd0, 8'd1, 8'hFF, 16'h0000, 1'b0);
        idle(4);

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 20) begin
            idle(1);
            wait_cnt++;
        end
        check("pending_summaries", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
